// File: rtl/quad_step_decoder.sv
// quad_step_decoder
// Turns raw quadrature encoder pins into a one-cycle count-enable pulse and a
// direction level for a downstream up/down counter. The pins pass through a
// synchroniser, a glitch filter, transition decode and an optional x1
// accumulator. A sticky error flag marks illegal (two-bit) jumps.

module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int X1_MODE     = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_a,
  input  logic i_b,
  input  logic i_dec_en,
  input  logic i_err_clr,
  output logic o_en,
  output logic o_up_down,
  output logic o_err
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  // Position of a {A,B} code along the up sequence 00 -> 10 -> 11 -> 01.
  // The difference of two positions (mod 4) gives +1 for up, -1 for down
  // and 2 for an illegal jump.
  function automatic logic [1:0] code_pos(input logic [1:0] code);
    return {code[0], code[1] ^ code[0]};
  endfunction

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             s_cur;
  logic [1:0]             s_prev;
  logic [1:0]             filt;
  logic [CNT_W-1:0]       run_cnt;
  logic [CNT_W-1:0]       run_next;
  logic                   primed;
  logic                   f_load;
  logic [1:0]             step_delta;

  logic                   evt_step;
  logic                   evt_dir;
  logic                   evt_ill;
  logic                   evt_en;

  logic [2:0]             acc;
  logic [3:0]             acc_sum;
  logic                   acc_full;

  // Metastability chains: shift each raw pin through SYNC_STAGES flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], i_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], i_b};
    end
  end

  assign s_cur = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Run length of the current synchronised code, the load condition for the
  // filtered state, and the step implied by moving from the old to new code.
  always_comb begin
    run_next   = (s_cur != s_prev) ? CNT_W'(1) : run_cnt + CNT_W'(1);
    f_load     = (s_cur != filt) && (run_next == CNT_W'(FILT_LEN));
    step_delta = code_pos(s_cur) - code_pos(filt);
  end

  // Glitch filter and transition decode; a decoded transition is registered
  // as an event that the output stage acts on one edge later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_prev   <= 2'b00;
      filt     <= 2'b00;
      run_cnt  <= '0;
      primed   <= 1'b0;
      evt_step <= 1'b0;
      evt_dir  <= 1'b0;
      evt_ill  <= 1'b0;
      evt_en   <= 1'b0;
    end else begin
      s_prev   <= s_cur;
      evt_step <= 1'b0;
      evt_ill  <= 1'b0;
      if (s_cur == filt) begin
        run_cnt <= '0;
      end else if (f_load) begin
        run_cnt <= '0;
        filt    <= s_cur;
        if (!primed) begin
          primed <= 1'b1;
        end else begin
          evt_en <= i_dec_en;
          case (step_delta)
            2'd1: begin
              evt_step <= 1'b1;
              evt_dir  <= 1'b1;
            end
            2'd3: begin
              evt_step <= 1'b1;
              evt_dir  <= 1'b0;
            end
            2'd2:    evt_ill <= 1'b1;
            default: ;
          endcase
        end
      end else begin
        run_cnt <= run_next;
      end
    end
  end

  // x1 accumulator evaluated one bit wider so that +4 and -4 are visible.
  always_comb begin
    acc_sum  = {acc[2], acc} + (evt_dir ? 4'b0001 : 4'b1111);
    acc_full = (acc_sum == 4'b0100) || (acc_sum == 4'b1100);
  end

  // Output stage: step pulse, direction, sticky error and x1 accumulator.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_en      <= 1'b0;
      o_up_down <= 1'b0;
      o_err     <= 1'b0;
      acc       <= '0;
    end else begin
      o_en <= 1'b0;

      if (evt_ill) begin
        o_err <= 1'b1;
      end else if (i_err_clr) begin
        o_err <= 1'b0;
      end

      if (evt_step && evt_en) begin
        if (X1_MODE == 0) begin
          o_en      <= 1'b1;
          o_up_down <= evt_dir;
        end else if (acc_full) begin
          o_en      <= 1'b1;
          o_up_down <= evt_dir;
        end
      end

      if (evt_ill || !i_dec_en || (X1_MODE == 0)) begin
        acc <= '0;
      end else if (evt_step && evt_en) begin
        acc <= acc_full ? 3'b000 : acc_sum[2:0];
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder
// Drives an x4 and an x1 decoder from the same encoder pins, compares both
// against a behavioural model every cycle, and pins the model with
// hand-computed pulse counts, latency and flag values.

module tb_quad_step_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
  localparam logic [1:0] UP_SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic a       = 1'b0;
  logic b       = 1'b0;
  logic dec_en  = 1'b1;
  logic err_clr = 1'b0;

  logic en_x4, ud_x4, err_x4;
  logic en_x1, ud_x1, err_x1;

  int checks    = 0;
  int errors    = 0;
  bit check_en  = 1'b0;
  int pulses_x4 = 0;
  int pulses_x1 = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  quad_step_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .X1_MODE    (0)
  ) dut_x4 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_a      (a),
    .i_b      (b),
    .i_dec_en (dec_en),
    .i_err_clr(err_clr),
    .o_en     (en_x4),
    .o_up_down(ud_x4),
    .o_err    (err_x4)
  );

  quad_step_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .X1_MODE    (1)
  ) dut_x1 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_a      (a),
    .i_b      (b),
    .i_dec_en (dec_en),
    .i_err_clr(err_clr),
    .o_en     (en_x1),
    .o_up_down(ud_x1),
    .o_err    (err_x1)
  );

  // Behavioural model state: a delay line of sampled pins, the length of the
  // current run of identical synchronised codes, the filtered code, and a
  // decoded step waiting to appear at the outputs one edge later.
  logic [1:0] delay_q [$];
  logic [1:0] run_val;
  int         run_len;
  logic [1:0] filt_m;
  bit         primed_m;
  bit         pend_step, pend_dir, pend_ill, pend_en;
  int         acc_m   [2];
  logic       exp_en  [2];
  logic       exp_ud  [2];
  logic       exp_err [2];

  function automatic int seq_pos(input logic [1:0] code);
    for (int i = 0; i < 4; i++) begin
      if (UP_SEQ[i] == code) return i;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    delay_q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) delay_q.push_back(2'b00);
    run_val   = 2'b00;
    run_len   = 0;
    filt_m    = 2'b00;
    primed_m  = 1'b0;
    pend_step = 1'b0;
    pend_dir  = 1'b0;
    pend_ill  = 1'b0;
    pend_en   = 1'b0;
    for (int m = 0; m < 2; m++) begin
      acc_m[m]   = 0;
      exp_en[m]  = 1'b0;
      exp_ud[m]  = 1'b0;
      exp_err[m] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    logic [1:0] s;
    int         d;
    for (int m = 0; m < 2; m++) begin
      exp_en[m] = 1'b0;
      if (pend_ill) begin
        exp_err[m] = 1'b1;
        acc_m[m]   = 0;
      end else begin
        if (err_clr) exp_err[m] = 1'b0;
        if (pend_step && pend_en) begin
          if (m == 0) begin
            exp_en[m] = 1'b1;
            exp_ud[m] = pend_dir;
          end else begin
            acc_m[m] += pend_dir ? 1 : -1;
            if (acc_m[m] == 4 || acc_m[m] == -4) begin
              exp_en[m] = 1'b1;
              exp_ud[m] = pend_dir;
              acc_m[m]  = 0;
            end
          end
        end
      end
      if (!dec_en) acc_m[m] = 0;
    end

    s = delay_q.pop_front();
    delay_q.push_back({a, b});
    if (s == run_val) begin
      if (run_len <= FILT_LEN) run_len++;
    end else begin
      run_val = s;
      run_len = 1;
    end

    pend_step = 1'b0;
    pend_ill  = 1'b0;
    if (s != filt_m && run_len == FILT_LEN) begin
      if (!primed_m) begin
        primed_m = 1'b1;
      end else begin
        d         = (seq_pos(s) - seq_pos(filt_m) + 4) % 4;
        pend_en   = dec_en;
        pend_step = (d == 1) || (d == 3);
        pend_dir  = (d == 1);
        pend_ill  = (d == 2);
      end
      filt_m = s;
    end
  endfunction

  // Advance the model on every clock edge; reset takes effect at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both decoders against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("cyc_en_x4",  en_x4,  exp_en[0]);
      check_output("cyc_ud_x4",  ud_x4,  exp_ud[0]);
      check_output("cyc_err_x4", err_x4, exp_err[0]);
      check_output("cyc_en_x1",  en_x1,  exp_en[1]);
      check_output("cyc_ud_x1",  ud_x1,  exp_ud[1]);
      check_output("cyc_err_x1", err_x1, exp_err[1]);
    end
  end

  // Count pulses seen on each decoder for the directed expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (en_x4) pulses_x4++;
      if (en_x1) pulses_x1++;
    end
  end

  task automatic apply_stimulus(input logic [1:0] code, input int cycles);
    {a, b} = code;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic snap(output int p4, output int p1);
    #1;
    p4 = pulses_x4;
    p1 = pulses_x1;
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized walk.
  initial begin
    int         p4, p1, q4, q1, lat;
    bit         found;
    logic [1:0] cur, nxt;

    {a, b}  = 2'b11;
    dec_en  = 1'b1;
    err_clr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;

    snap(p4, p1);
    apply_stimulus(2'b11, 20);
    snap(q4, q1);
    check_output("prime_pulses_x4", q4 - p4, 0);
    check_output("prime_pulses_x1", q1 - p1, 0);
    check_output("prime_err_x4", err_x4, 0);
    check_output("prime_err_x1", err_x1, 0);

    snap(p4, p1);
    apply_stimulus(2'b10, 10);
    apply_stimulus(2'b00, 10);
    snap(q4, q1);
    check_output("to_zero_pulses_x4", q4 - p4, 2);
    check_output("to_zero_dir_x4", ud_x4, 0);

    snap(p4, p1);
    {a, b} = 2'b10;
    found  = 1'b0;
    lat    = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (en_x4) begin
        found = 1'b1;
        lat   = i;
      end
    end
    check_output("latency_edges", lat, 7);
    repeat (3) @(negedge clk);
    apply_stimulus(2'b11, 10);
    apply_stimulus(2'b01, 10);
    apply_stimulus(2'b00, 10);
    snap(q4, q1);
    check_output("up_pulses_x4", q4 - p4, 4);
    check_output("up_dir_x4", ud_x4, 1);
    check_output("up_pulses_x1", q1 - p1, 0);

    snap(p4, p1);
    apply_stimulus(2'b01, 10);
    apply_stimulus(2'b11, 10);
    apply_stimulus(2'b10, 10);
    apply_stimulus(2'b00, 10);
    snap(q4, q1);
    check_output("down_pulses_x4", q4 - p4, 4);
    check_output("down_dir_x4", ud_x4, 0);
    apply_stimulus(2'b00, 10);
    check_output("down_dir_hold_x4", ud_x4, 0);

    snap(p4, p1);
    apply_stimulus(2'b10, 3);
    apply_stimulus(2'b00, 12);
    snap(q4, q1);
    check_output("glitch_pulses_x4", q4 - p4, 0);
    check_output("glitch_pulses_x1", q1 - p1, 0);
    check_output("glitch_err_x4", err_x4, 0);

    snap(p4, p1);
    apply_stimulus(2'b11, 10);
    snap(q4, q1);
    check_output("illegal_pulses_x4", q4 - p4, 0);
    check_output("illegal_err_x4", err_x4, 1);
    check_output("illegal_err_x1", err_x1, 1);
    apply_stimulus(2'b11, 10);
    check_output("sticky_err_x4", err_x4, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_output("cleared_err_x4", err_x4, 0);
    check_output("cleared_err_x1", err_x1, 0);
    snap(p4, p1);
    apply_stimulus(2'b01, 10);
    snap(q4, q1);
    check_output("after_illegal_pulses_x4", q4 - p4, 1);
    check_output("after_illegal_dir_x4", ud_x4, 1);

    dec_en = 1'b0;
    repeat (3) @(negedge clk);
    dec_en = 1'b1;
    snap(p4, p1);
    for (int i = 0; i < 8; i++) apply_stimulus(UP_SEQ[i % 4], 8);
    snap(q4, q1);
    check_output("x1_eight_up_pulses", q1 - p1, 2);
    check_output("x1_eight_up_dir", ud_x1, 1);
    check_output("x4_eight_up_pulses", q4 - p4, 8);

    snap(p4, p1);
    apply_stimulus(2'b00, 8);
    apply_stimulus(2'b10, 8);
    apply_stimulus(2'b00, 8);
    apply_stimulus(2'b01, 8);
    snap(q4, q1);
    check_output("x1_reversal_pulses", q1 - p1, 0);
    snap(p4, p1);
    for (int i = 0; i < 4; i++) apply_stimulus(UP_SEQ[i], 8);
    snap(q4, q1);
    check_output("x1_four_up_pulses", q1 - p1, 1);

    {a, b} = 2'b11;
    found  = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (en_x4) found = 1'b1;
    end
    check_output("reset_pulse_seen", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_en_x4", en_x4, 0);
    check_output("reset_en_x1", en_x1, 0);
    check_output("reset_err_x4", err_x4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    snap(p4, p1);
    apply_stimulus(2'b11, 12);
    snap(q4, q1);
    check_output("reprime_pulses_x4", q4 - p4, 0);
    snap(p4, p1);
    apply_stimulus(2'b10, 10);
    snap(q4, q1);
    check_output("reprimed_pulses_x4", q4 - p4, 1);
    check_output("reprimed_dir_x4", ud_x4, 0);

    cur = 2'b10;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       nxt = 2'($urandom_range(0, 3));
        1, 2, 3: nxt = UP_SEQ[(seq_pos(cur) + 1) % 4];
        default: nxt = UP_SEQ[(seq_pos(cur) + 3) % 4];
      endcase
      if ($urandom_range(0, 9) == 0) dec_en = ~dec_en;
      err_clr = ($urandom_range(0, 7) == 0);
      apply_stimulus(nxt, $urandom_range(1, 12));
      cur = nxt;
    end
    dec_en  = 1'b1;
    err_clr = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
